// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   - access size encodings (SIZE_BYTE/HALF/WORD)
//   - FSM state enum lsu_state_t
//   - lane width helpers
//   - SUBWORD_EN mirrors the LSU_SUBWORD_EN build macro so other code can
//     query the configuration without its own preprocessor guards.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD_EN = 1'b1;
`else
  localparam bit SUBWORD_EN = 1'b0;
`endif

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane handling.
//   word        : registered memory word
//   addr        : byte offset within the word (selects the lane)
//   size        : access size
//   is_unsigned : zero-extend (1) / sign-extend (0) sub-word loads
//   wdata       : right-justified store data
//   load_data   : extended load value
//   store_word  : word with the store lane merged in, other lanes kept
// Compiled only when LSU_SUBWORD_EN is defined.
`ifdef LSU_SUBWORD_EN
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        addr,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] store_word
);

  logic [BYTE_W-1:0] lane_b;
  logic [HALF_W-1:0] lane_h;

  // lane k starts at bit 8k; half lane starts at bit 16*addr[1]
  assign lane_b = word[{addr, 3'b000} +: BYTE_W];
  assign lane_h = word[{addr[1], 4'b0000} +: HALF_W];

  always_comb begin
    load_data  = word;
    store_word = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data  = {{(WORD_W-BYTE_W){~is_unsigned & lane_b[BYTE_W-1]}}, lane_b};
        store_word = word;
        store_word[{addr, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      SIZE_HALF: begin
        load_data  = {{(WORD_W-HALF_W){~is_unsigned & lane_h[HALF_W-1]}}, lane_h};
        store_word = word;
        store_word[{addr[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      end
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule
`endif

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for the core's
// word-addressed data memory.
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_write/size/unsigned/addr/wdata : latched request fields
//   resp_valid/rdata/error     : one-cycle completion pulse
//   mem_read/write/addr/wdata  : memory strobes, word index, write word
//   mem_rdata                  : memory read data (same cycle as mem_read)
// Build option LSU_SUBWORD_EN enables byte/half accesses; without it only
// aligned word accesses are legal and sub-word sizes report an error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, state_nxt;
  logic        write_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rword_q;
  logic        req_err;
  logic        accept;
  logic [31:0] load_data, store_word;

  assign accept = req_valid && (state == IDLE);

  // request legality, evaluated on the live request at accept time
  always_comb begin
    case (req_size)
      SIZE_BYTE: req_err = !SUBWORD_EN;
      SIZE_HALF: req_err = !SUBWORD_EN || req_addr[0];
      SIZE_WORD: req_err = (req_addr[1:0] != 2'b00);
      default:   req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) req_err = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) begin
        if (req_err)                     state_nxt = RESP;
        else if (!req_write)             state_nxt = READ;
        else if (req_size == SIZE_WORD)  state_nxt = WRITE;
        else                             state_nxt = READ;
      end
      // a write after a read only happens for sub-word stores
      READ:    state_nxt = (SUBWORD_EN && write_q) ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        write_q <= req_write;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == READ) rword_q <= mem_rdata;
    end
  end

`ifdef LSU_SUBWORD_EN
  lsu_lane_align u_align (
    .word        (rword_q),
    .addr        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );
`else
  // word-only build: no lane handling, offset/size/sign fields are dead
  logic unused_sub;
  assign unused_sub = ^{req_unsigned, uns_q, size_q, addr_q[1:0]};
  assign load_data  = rword_q;
  assign store_word = wdata_q;
`endif

  // all outputs decode from registered state, so async reset clears them
  assign req_ready  = (state == IDLE);
  assign mem_read   = (state == READ);
  assign mem_write  = (state == WRITE);
  assign resp_valid = (state == RESP);
  assign mem_addr   = {2'b00, addr_q[31:2]};
  assign mem_wdata  = mem_write ? store_word : 32'h0;
  assign resp_rdata = (resp_valid && !write_q && !err_q) ? load_data : 32'h0;
  assign resp_error = resp_valid && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench. A behavioural model computes the
// expected response at accept time and queues it; a negedge monitor pops and
// compares whenever resp_valid is seen. A bench-side memory array serves the
// DUT and is compared against the model memory at the end.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // bench memory with a backdoor port for setup
  logic [31:0] tmem [MW];
  logic        bd_we = 1'b0;
  int          bd_idx = 0;
  logic [31:0] bd_data = '0;

  assign mem_rdata = (mem_addr < MW) ? tmem[mem_addr[3:0]] : 32'h0;

  always @(posedge clk) begin
    if (bd_we) tmem[bd_idx] <= bd_data;
    else if (mem_write && mem_addr < MW) tmem[mem_addr[3:0]] <= mem_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] idx;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [MW];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0, rd_cnt = 0, wr_cnt = 0;
  logic        both_seen = 1'b0, addr_bad = 1'b0;
  logic [31:0] cur_idx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: response, latency and strobe counts from the access rules
  function automatic exp_t model(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic [31:0] word, v, mask;
    int sh;
    e.idx = a >> 2;
    e.err = (sz == 2'd3) || (!SUBWORD_EN && sz != 2'd2) ||
            (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (e.idx >= MW);
    e.rdata = 0; e.nrd = 0; e.nwr = 0; e.lat = 1;
    if (!e.err) begin
      word = ref_mem[e.idx[3:0]];
      if (sz == 2'd0) begin sh = 8 * a[1:0];  mask = 32'hFF;   end
      else            begin sh = 16 * a[1];   mask = 32'hFFFF; end
      if (!w) begin
        e.lat = 2; e.nrd = 1;
        if (sz == 2'd2) e.rdata = word;
        else begin
          v = (word >> sh) & mask;
          if (!u && v > (mask >> 1)) v = v | ~mask;
          e.rdata = v;
        end
      end else if (sz == 2'd2) begin
        e.lat = 2; e.nwr = 1;
        ref_mem[e.idx[3:0]] = wd;
      end else begin
        e.lat = 3; e.nrd = 1; e.nwr = 1;
        ref_mem[e.idx[3:0]] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      end
    end
    return e;
  endfunction

  // monitor: strobe bookkeeping, response checking, accept capture
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_read && mem_write) both_seen = 1'b1;
      if (mem_read)  begin rd_cnt++; if (mem_addr != cur_idx) addr_bad = 1'b1; end
      if (mem_write) begin wr_cnt++; if (mem_addr != cur_idx) addr_bad = 1'b1; end
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: got resp_valid with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_error", 32'(resp_error), 32'(e.err));
          check("latency", cyc - acc_cyc, e.lat);
          check("read_strobes", rd_cnt, e.nrd);
          check("write_strobes", wr_cnt, e.nwr);
          check("strobe_overlap", 32'(both_seen), 0);
          check("strobe_addr", 32'(addr_bad), 0);
        end
      end
      if (req_valid && req_ready) begin
        check("outstanding_at_accept", sb_q.size(), 0);
        e = model(req_write, req_size, req_unsigned, req_addr, req_wdata);
        sb_q.push_back(e);
        acc_cyc = cyc; rd_cnt = 0; wr_cnt = 0;
        both_seen = 1'b0; addr_bad = 1'b0; cur_idx = e.idx;
      end
    end
  end

  task automatic poke(input int i, input logic [31:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_idx = i; bd_data = d; ref_mem[i] = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic scramble();
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    int t = 0;
    @(posedge clk); #1;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got req_ready 0 expected 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();  // later req_* changes must not disturb the latched request
    drain();
  endtask

  initial begin
    logic [31:0] saved;
    int t;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < MW; i++) poke(i, $urandom);

    // reset state
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_error", 32'(resp_error), 0);
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk); rst_n = 1'b1;

    // directed cases
    poke(2, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    poke(2, 32'h0000_8000);
    issue(1'b0, 2'd0, 1'b0, 32'h9, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h9, 32'h0);
    poke(3, 32'h1122_3344);
    issue(1'b1, 2'd1, 1'b0, 32'hE, 32'h0000_ABCD);
    issue(1'b0, 2'd1, 1'b1, 32'hE, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h4, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h3F, 32'h5A);
    issue(1'b1, 2'd2, 1'b0, 32'h3C, 32'hCAFE_F00D);

    // reset in the middle of a word store's WRITE cycle
    saved = ref_mem[4];
    @(posedge clk); #1;
    req_write = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = ~saved; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    t = 0;
    while (!mem_write && t < 10) begin @(negedge clk); t++; end
    check("write_reached", 32'(mem_write), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_cut_mem_write", 32'(mem_write), 0);
    check("rst_cut_req_ready", 32'(req_ready), 1);
    check("rst_cut_mem_wdata", mem_wdata, 0);
    sb_q.delete();
    ref_mem[4] = saved;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_word_kept", tmem[4], saved);
    check("rst_release_ready", 32'(req_ready), 1);

    // randomized stream, req_valid mostly held, fields churn every cycle
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      scramble();
      if ($urandom_range(0, 3) != 0) req_addr = $urandom_range(0, MW * 4 + 7);
      req_valid = ($urandom_range(0, 7) != 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    for (int i = 0; i < MW; i++) check($sformatf("mem[%0d]", i), tmem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
